round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 16: maximum consecutive grant cycles per ownership, legal range 2..255, used only with ARB_TIMEOUT_EN.
REQ-003 Port clock  input  1  single clock; all state changes on posedge clock.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port req  input  NUM_REQ  active-high request, bit i from agent i.
REQ-006 Port gnt  output  NUM_REQ  registered, one-hot or zero grant, bit i to agent i.
REQ-007 Port gnt_id  output  clog2(NUM_REQ)  registered index of the current owner, 0 when no grant.
REQ-008 Port busy  output  1  registered, high while any gnt bit is high.
REQ-009 Port expired  output  1  registered one-cycle pulse on a forced release, tied 0 without ARB_TIMEOUT_EN.

Function
REQ-010 The state machine SHALL have exactly two states, IDLE and GRANT.
REQ-011 In IDLE with req nonzero, the arbiter SHALL pick the first set req bit searching upward from (ptr+1) mod NUM_REQ, wrapping to 0.
REQ-012 At the next edge after that pick, gnt SHALL assert the winner's bit, gnt_id SHALL hold its index, busy SHALL be 1, and the state SHALL be GRANT: one-cycle latency from req to gnt.
REQ-013 ptr SHALL be loaded with the winner index on the edge that issues the grant.
REQ-014 In IDLE with req all zero, the arbiter SHALL stay in IDLE with gnt=0 and ptr unchanged.
REQ-015 In GRANT, while req[gnt_id] is 1 and no timeout occurs, gnt SHALL hold unchanged, and other requests SHALL be ignored.
REQ-016 In GRANT, when req[gnt_id] is 0, the arbiter SHALL go to IDLE at the next edge with gnt=0, gnt_id=0 and busy=0.
REQ-017 Every release SHALL be followed by at least one IDLE cycle, so there are never back-to-back grants without a gnt=0 cycle.
REQ-018 At most one gnt bit SHALL be high in any cycle.
REQ-019 Request bits that toggle during IDLE SHALL be sampled only on the arbitration cycle, with no latching of earlier requests.

Reset
REQ-020 While reset is high at a clock edge, the block SHALL set state=IDLE, gnt=0, gnt_id=0, busy=0, expired=0, hold counter=0 and ptr=NUM_REQ-1, so agent 0 has first priority.
REQ-021 Reset SHALL override all other inputs, including mid-grant, and gnt SHALL be 0 on the edge where reset is sampled.
REQ-022 After reset falls, the first arbitration SHALL occur on the first edge with reset low.

Configuration
REQ-023 When the macro ARB_TIMEOUT_EN is defined, the block SHALL contain a hold counter of width clog2(MAX_HOLD+1).
REQ-024 The hold counter SHALL clear on grant issue and increment each GRANT cycle.
REQ-025 When the grant has been high MAX_HOLD cycles and req[gnt_id] is still 1, the arbiter SHALL go to IDLE with expired=1 for one cycle.
REQ-026 After a forced release, the next search SHALL start at owner+1, and if only the owner still requests, it SHALL be re-granted after the IDLE cycle.
REQ-027 If req[gnt_id] falls in the same cycle the count reaches MAX_HOLD, the release SHALL be a normal release with expired=0.
REQ-028 When ARB_TIMEOUT_EN is not defined, there SHALL be no counter, grants SHALL be held indefinitely, and expired SHALL be constant 0.

Structure
REQ-029 The shared package arb_pkg SHALL hold the state type (IDLE, GRANT) and the default NUM_REQ and MAX_HOLD constants.
REQ-030 The block SHALL instantiate one combinational sub-module, rr_pick, a rotating priority encoder: inputs req and ptr, outputs valid and index.
REQ-031 All outputs SHALL be driven directly from flops.

Verification
REQ-032 Reset, then req=4'b0101 held: the bench SHALL see gnt=0001 one cycle later; after req[0] drops, one IDLE cycle, then gnt=0100 and gnt_id=2.
REQ-033 req=4'b1111 with each owner dropping its bit after 3 grant cycles: the bench SHALL see grant order 0,1,2,3,0 with a gnt=0 cycle between each.
REQ-034 The bench SHALL assert reset during GRANT with gnt=0010 and see gnt=0, busy=0 on that edge, then with req=4'b0010 after reset see gnt=0010 first.
REQ-035 With ARB_TIMEOUT_EN defined and MAX_HOLD=4, req=4'b0011 held: the bench SHALL see gnt=0001 for 4 cycles, expired pulses, one IDLE cycle, then gnt=0010.
REQ-036 With ARB_TIMEOUT_EN defined, MAX_HOLD=4, and req[0] falling on the 4th grant cycle: the bench SHALL see expired=0.
REQ-037 Without ARB_TIMEOUT_EN, req=4'b0001 held for 100 cycles: the bench SHALL see gnt=0001 continuously and expired never 1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter and its priority encoder.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_NUM_REQ  = 4;
    localparam int ARB_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request strictly after ptr, wrapping around.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               valid,
    output logic [IDW-1:0]     index
);

    // Scan from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [IDW-1:0] pos;
            pos = IDW'((int'(ptr) + k) % NUM_REQ);
            if (req[pos]) begin
                valid = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Two-state round-robin arbiter with registered grant outputs.
// Define ARB_TIMEOUT_EN to add a MAX_HOLD grant timeout with the expired pulse.
module round_robin_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ  = ARB_NUM_REQ,
    parameter  int MAX_HOLD = ARB_MAX_HOLD,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               busy,
    output logic               expired
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("round_robin_arbiter: NUM_REQ must be 2..8 and MAX_HOLD 2..255");
    end

    arb_state_t         r_state,  w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt,    w_gnt_nxt;
    logic [IDW-1:0]     r_gnt_id, w_gnt_id_nxt;
    logic [IDW-1:0]     r_ptr,    w_ptr_nxt;
    logic               r_busy,   w_busy_nxt;
    logic               w_pick_valid;
    logic [IDW-1:0]     w_pick_idx;
    logic               w_owner_req;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic          r_expired,  w_expired_nxt;
    logic          w_timeout;

    // Counter holds completed grant cycles minus one, so this is the MAX_HOLD-th cycle.
    assign w_timeout = (r_hold_cnt == CW'(MAX_HOLD - 1));
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .index (w_pick_idx)
    );

    assign w_owner_req = req[r_gnt_id];

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        w_busy_nxt   = r_busy;
`ifdef ARB_TIMEOUT_EN
        w_hold_cnt_nxt = r_hold_cnt;
        w_expired_nxt  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
                w_busy_nxt   = 1'b0;
                if (w_pick_valid) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = NUM_REQ'(1) << w_pick_idx;
                    w_gnt_id_nxt = w_pick_idx;
                    w_ptr_nxt    = w_pick_idx;
                    w_busy_nxt   = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_hold_cnt_nxt = '0;
`endif
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                if (!w_owner_req || w_timeout) begin
                    w_expired_nxt = w_owner_req;
`else
                if (!w_owner_req) begin
`endif
                    w_state_nxt  = IDLE;
                    w_gnt_nxt    = '0;
                    w_gnt_id_nxt = '0;
                    w_busy_nxt   = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs and arbitration state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_ptr    <= IDW'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= '0;
            r_expired  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_busy   <= w_busy_nxt;
            r_ptr    <= w_ptr_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= w_hold_cnt_nxt;
            r_expired  <= w_expired_nxt;
`endif
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;
`ifdef ARB_TIMEOUT_EN
    assign expired = r_expired;
`else
    assign expired = 1'b0;
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_round_robin_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_id;
    logic               busy;
    logic               expired;

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner index (-1 when nobody holds), last winner, cycles the grant has been high.
    int m_owner;
    int m_last;
    int m_held;
    bit m_exp;

    round_robin_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .expired (expired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rs, input logic [NUM_REQ-1:0] r);
        if (rs) begin
            m_owner = -1;
            m_last  = NUM_REQ - 1;
            m_held  = 0;
            m_exp   = 1'b0;
        end else begin
            m_exp = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int c;
                    c = (m_last + k) % NUM_REQ;
                    if (m_owner < 0 && r[c]) begin
                        m_owner = c;
                        m_last  = c;
                        m_held  = 1;
                    end
                end
            end else if (!r[m_owner]) begin
                m_owner = -1;
            end else if (TO_EN && m_held == MAX_HOLD) begin
                m_owner = -1;
                m_exp   = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    // Apply inputs for one cycle, advance the model on the edge, then compare.
    task automatic step(input logic [NUM_REQ-1:0] r, input logic rs);
        logic [NUM_REQ-1:0] e_gnt;
        req   = r;
        reset = rs;
        @(posedge clock);
        model_edge(rs, r);
        #1;
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        chk("gnt",     8'(gnt),     8'(e_gnt));
        chk("gnt_id",  8'(gnt_id),  (m_owner >= 0) ? 8'(m_owner) : 8'd0);
        chk("busy",    8'(busy),    8'(m_owner >= 0));
        chk("expired", 8'(expired), 8'(m_exp));
        chk("onehot0", 8'($onehot0(gnt)), 8'd1);
    endtask

    initial begin
        req   = '0;
        reset = 1'b1;

        // Reset state
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("rst_gnt", 8'(gnt), 8'h00);

        // Agent 0 first, then agent 2 after one idle cycle
        step(4'b0101, 1'b0);
        chk("p1_first", 8'(gnt), 8'h01);
        step(4'b0101, 1'b0);
        step(4'b0101, 1'b0);
        step(4'b0100, 1'b0);
        chk("p1_idle", 8'(gnt), 8'h00);
        step(4'b0100, 1'b0);
        chk("p1_second", 8'(gnt), 8'h04);
        chk("p1_id", 8'(gnt_id), 8'h02);
        step(4'b0000, 1'b0);

        // Full rotation 0,1,2,3,0 with three-cycle holds
        step(4'b0000, 1'b1);
        for (int g = 0; g < 5; g++) begin
            int eo;
            eo = g % NUM_REQ;
            step(4'b1111, 1'b0);
            chk("rr_order", 8'(gnt), 8'(1 << eo));
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b0);
            step(4'b1111 & ~(4'b0001 << eo), 1'b0);
            chk("rr_gap", 8'(gnt), 8'h00);
        end

        // Reset in the middle of a grant
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        chk("mid_gnt", 8'(gnt), 8'h02);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        chk("mid_rst_gnt", 8'(gnt), 8'h00);
        chk("mid_rst_busy", 8'(busy), 8'h00);
        step(4'b0010, 1'b0);
        chk("post_rst_gnt", 8'(gnt), 8'h02);
        step(4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Forced release after MAX_HOLD cycles, then the other requester
        step(4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(4'b0011, 1'b0);
            chk("to_hold", 8'(gnt), 8'h01);
        end
        step(4'b0011, 1'b0);
        chk("to_expired", 8'(expired), 8'h01);
        chk("to_idle", 8'(gnt), 8'h00);
        step(4'b0011, 1'b0);
        chk("to_next", 8'(gnt), 8'h02);
        chk("to_pulse", 8'(expired), 8'h00);

        // Owner drops exactly in the last allowed cycle: ordinary release
        step(4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        chk("to_edge_exp", 8'(expired), 8'h00);
        chk("to_edge_gnt", 8'(gnt), 8'h00);
`else
        // Without the timeout a grant is held indefinitely
        step(4'b0000, 1'b1);
        for (int i = 0; i < 100; i++) begin
            step(4'b0001, 1'b0);
            chk("hold_gnt", 8'(gnt), 8'h01);
            chk("hold_exp", 8'(expired), 8'h00);
        end
`endif

        // Random traffic with occasional resets
        step(4'b0000, 1'b1);
        for (int i = 0; i < 400; i++) begin
            logic [NUM_REQ-1:0] r;
            logic               rs;
            r  = NUM_REQ'($urandom_range(0, 15));
            rs = ($urandom_range(0, 49) == 0);
            step(r, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
